// File: rtl/uart_pkg.sv
// uart_pkg: shared types and field encodings for the UART transmit path.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    // data_bit_num encoding
    localparam logic [1:0] DATA_BITS_5 = 2'b00;
    localparam logic [1:0] DATA_BITS_6 = 2'b01;
    localparam logic [1:0] DATA_BITS_7 = 2'b10;
    localparam logic [1:0] DATA_BITS_8 = 2'b11;

    // stop_bit_num encoding
    localparam logic STOP_BITS_1 = 1'b0;
    localparam logic STOP_BITS_2 = 1'b1;

    // parity_type encoding
    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    // Index of the last data bit sent: 5..8 bits map to 4..7.
    function automatic logic [2:0] last_data_idx(input logic [1:0] dbn);
        return {1'b1, dbn};
    endfunction

    // Mask selecting the data bits that actually go on the wire.
    function automatic logic [7:0] data_mask(input logic [1:0] dbn);
        logic [7:0] m;
        m = 8'hFF;
        case (dbn)
            DATA_BITS_5: m = 8'h1F;
            DATA_BITS_6: m = 8'h3F;
            DATA_BITS_7: m = 8'h7F;
            default:     m = 8'hFF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period counter, 0..CLK_DIV-1, ticks on the last count.
// Latency: tick is combinational from the count; clr takes effect on the next edge.
// Backpressure: none; free-running between clears.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLK_DIV = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == CNT_LAST);

    // Count cycles within a bit; restart on frame launch and at each bit boundary.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART transmitter, 5-8 data bits, optional even/odd parity, 1-2 stop bits.
// Latency: tx_o goes low on the launch edge; a frame lasts CLK_DIV*(1+N+P+S) cycles.
// Backpressure: none; start edges while busy are dropped, status via tx_busy_o/tx_done_o.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int CLK_DIV = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_tx_i,
    input  logic [31:0] tx_data_i,
    input  logic [1:0]  data_bit_num_i,
    input  logic        stop_bit_num_i,
    input  logic        parity_en_i,
    input  logic        parity_type_i,
    output logic        tx_o,
    output logic        tx_busy_o,
    output logic        tx_done_o
);

    tx_state_t  state;
    tx_state_t  state_nxt;
    logic       start_q;
    logic       launch;
    logic       tick;

    // Frame parameters captured at launch so mid-frame register writes are harmless.
    logic [7:0] data_q;
    logic [1:0] dbn_q;
    logic       sbn_q;
    logic       pen_q;
    logic       ptype_q;

    logic [2:0] bit_idx;
    logic [2:0] bit_idx_nxt;
    logic       stop_idx;
    logic       stop_idx_nxt;
    logic       tx_nxt;
    logic       done_nxt;
    logic       parity_bit;
    logic       unused_data_hi;

    // Only the low byte is transmitted.
    assign unused_data_hi = ^tx_data_i[31:8];

    // Rising edge of the level request, honoured only when idle.
    assign launch     = start_tx_i & ~start_q & (state == ST_IDLE);
    assign parity_bit = (^(data_q & data_mask(dbn_q))) ^ (ptype_q == PARITY_ODD);
    assign tx_busy_o  = (state != ST_IDLE);

    uart_baud_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_baud_gen (
        .clk   (clk),
        .reset (reset),
        .clr   (launch),
        .tick  (tick)
    );

    // State, serial line, status and launch-time captures.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            start_q   <= 1'b1;
            tx_o      <= 1'b1;
            tx_done_o <= 1'b0;
            bit_idx   <= '0;
            stop_idx  <= 1'b0;
            data_q    <= '0;
            dbn_q     <= '0;
            sbn_q     <= 1'b0;
            pen_q     <= 1'b0;
            ptype_q   <= 1'b0;
        end else begin
            state     <= state_nxt;
            start_q   <= start_tx_i;
            tx_o      <= tx_nxt;
            tx_done_o <= done_nxt;
            bit_idx   <= bit_idx_nxt;
            stop_idx  <= stop_idx_nxt;
            if (launch) begin
                data_q  <= tx_data_i[7:0];
                dbn_q   <= data_bit_num_i;
                sbn_q   <= stop_bit_num_i;
                pen_q   <= parity_en_i;
                ptype_q <= parity_type_i;
            end
        end
    end

    // Next state plus the value tx_o takes on entering/continuing that state.
    always_comb begin
        state_nxt    = state;
        bit_idx_nxt  = bit_idx;
        stop_idx_nxt = stop_idx;
        tx_nxt       = tx_o;
        done_nxt     = tx_done_o;
        case (state)
            ST_IDLE: begin
                tx_nxt = 1'b1;
                if (launch) begin
                    state_nxt    = ST_START;
                    tx_nxt       = 1'b0;
                    bit_idx_nxt  = '0;
                    stop_idx_nxt = 1'b0;
                    done_nxt     = 1'b0;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_nxt   = ST_DATA;
                    bit_idx_nxt = '0;
                    tx_nxt      = data_q[0];
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (bit_idx == last_data_idx(dbn_q)) begin
                        if (pen_q) begin
                            state_nxt = ST_PARITY;
                            tx_nxt    = parity_bit;
                        end else begin
                            state_nxt    = ST_STOP;
                            stop_idx_nxt = 1'b0;
                            tx_nxt       = 1'b1;
                        end
                    end else begin
                        bit_idx_nxt = bit_idx + 3'd1;
                        tx_nxt      = data_q[bit_idx + 3'd1];
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    state_nxt    = ST_STOP;
                    stop_idx_nxt = 1'b0;
                    tx_nxt       = 1'b1;
                end
            end
            ST_STOP: begin
                tx_nxt = 1'b1;
                if (tick) begin
                    if (stop_idx || (sbn_q == STOP_BITS_1)) begin
                        state_nxt = ST_IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        stop_idx_nxt = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                tx_nxt    = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: scoreboard bench for uart_tx_ctrl at CLK_DIV=4.
// Latency: expected line bits queued at launch, compared every cycle of each bit.
// Backpressure: n/a.
module tb_uart_tx_ctrl;

    localparam int CLK_DIV = 4;

    logic        clk;
    logic        reset;
    logic        start_tx_i;
    logic [31:0] tx_data_i;
    logic [1:0]  data_bit_num_i;
    logic        stop_bit_num_i;
    logic        parity_en_i;
    logic        parity_type_i;
    logic        tx_o;
    logic        tx_busy_o;
    logic        tx_done_o;

    int   n_chk = 0;
    int   n_bad = 0;
    logic exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    uart_tx_ctrl #(
        .CLK_DIV (CLK_DIV)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start_tx_i     (start_tx_i),
        .tx_data_i      (tx_data_i),
        .data_bit_num_i (data_bit_num_i),
        .stop_bit_num_i (stop_bit_num_i),
        .parity_en_i    (parity_en_i),
        .parity_type_i  (parity_type_i),
        .tx_o           (tx_o),
        .tx_busy_o      (tx_busy_o),
        .tx_done_o      (tx_done_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference frame: start, N data bits LSB first, optional parity, stop bits.
    task automatic push_frame(input logic [7:0] d, input logic [1:0] dbn,
                              input logic sbn, input logic pen, input logic ptype);
        int   n;
        logic par;
        n   = 5 + int'(dbn);
        par = ptype;
        exp_q.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(d[i]);
            par = par ^ d[i];
        end
        if (pen) exp_q.push_back(par);
        exp_q.push_back(1'b1);
        if (sbn) exp_q.push_back(1'b1);
    endtask

    // mode 0: drop start early; 1: hold start, re-edge while busy; 2: change inputs mid-frame.
    task automatic run_frame(input string tag, input logic [7:0] d, input logic [1:0] dbn,
                             input logic sbn, input logic pen, input logic ptype, input int mode);
        int   k;
        int   nbits;
        logic b;
        @(negedge clk);
        tx_data_i      = {24'hA5A5A5, d};
        data_bit_num_i = dbn;
        stop_bit_num_i = sbn;
        parity_en_i    = pen;
        parity_type_i  = ptype;
        start_tx_i     = 1'b1;
        push_frame(d, dbn, sbn, pen, ptype);
        nbits = exp_q.size();
        k = 0;
        while (exp_q.size() > 0) begin
            b = exp_q.pop_front();
            for (int c = 0; c < CLK_DIV; c++) begin
                @(negedge clk);
                chk({tag, "_tx"}, 32'(tx_o), 32'(b));
                chk({tag, "_busy"}, 32'(tx_busy_o), 32'd1);
                chk({tag, "_done_lo"}, 32'(tx_done_o), 32'd0);
                if (mode != 1 && k == 2) start_tx_i = 1'b0;
                if (mode == 1 && k == 6) start_tx_i = 1'b0;
                if (mode == 1 && k == 10) start_tx_i = 1'b1;
                if (mode == 2 && k == 9) begin
                    data_bit_num_i = 2'b00;
                    tx_data_i      = ~tx_data_i;
                    parity_en_i    = ~parity_en_i;
                    stop_bit_num_i = ~stop_bit_num_i;
                end
                k++;
            end
        end
        @(negedge clk);
        chk({tag, "_len"}, 32'(k), 32'(nbits * CLK_DIV));
        chk({tag, "_done"}, 32'(tx_done_o), 32'd1);
        chk({tag, "_end_busy"}, 32'(tx_busy_o), 32'd0);
        chk({tag, "_end_tx"}, 32'(tx_o), 32'd1);
    endtask

    initial begin
        logic [7:0] rd;
        logic [1:0] rdbn;
        logic       rsbn, rpen, rpt;

        reset          = 1'b1;
        start_tx_i     = 1'b0;
        tx_data_i      = '0;
        data_bit_num_i = 2'b00;
        stop_bit_num_i = 1'b0;
        parity_en_i    = 1'b0;
        parity_type_i  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(tx_o), 32'd1);
        chk("rst_busy", 32'(tx_busy_o), 32'd0);
        chk("rst_done", 32'(tx_done_o), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_tx", 32'(tx_o), 32'd1);

        run_frame("f8n1", 8'h55, 2'b11, 1'b0, 1'b0, 1'b0, 0);
        repeat (3) @(negedge clk);
        chk("done_hold", 32'(tx_done_o), 32'd1);
        run_frame("f5e2", 8'h1F, 2'b00, 1'b1, 1'b1, 1'b0, 0);
        run_frame("f7o1", 8'h00, 2'b10, 1'b0, 1'b1, 1'b1, 0);

        // Start held across completion (with a re-edge while busy) must not relaunch.
        run_frame("hold", 8'hC3, 2'b11, 1'b0, 1'b0, 1'b0, 1);
        repeat (3 * CLK_DIV) begin
            @(negedge clk);
            chk("hold_busy", 32'(tx_busy_o), 32'd0);
            chk("hold_done", 32'(tx_done_o), 32'd1);
            chk("hold_tx", 32'(tx_o), 32'd1);
        end
        start_tx_i = 1'b0;
        @(negedge clk);
        run_frame("relaunch", 8'h3C, 2'b11, 1'b0, 1'b1, 1'b0, 0);

        run_frame("midchg", 8'h96, 2'b11, 1'b0, 1'b0, 1'b0, 2);

        for (int i = 0; i < 6; i++) begin
            rd   = 8'($urandom_range(0, 255));
            rdbn = 2'($urandom_range(0, 3));
            rsbn = 1'($urandom_range(0, 1));
            rpen = 1'($urandom_range(0, 1));
            rpt  = 1'($urandom_range(0, 1));
            run_frame("rnd", rd, rdbn, rsbn, rpen, rpt, 0);
        end

        // Reset in DATA bit 3 aborts the frame; held start must not launch afterwards.
        @(negedge clk);
        tx_data_i      = 32'h0;
        data_bit_num_i = 2'b11;
        stop_bit_num_i = 1'b0;
        parity_en_i    = 1'b0;
        start_tx_i     = 1'b1;
        repeat (4 * CLK_DIV + 2) @(negedge clk);
        chk("pre_rst_tx", 32'(tx_o), 32'd0);
        chk("pre_rst_busy", 32'(tx_busy_o), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_tx", 32'(tx_o), 32'd1);
        chk("midrst_busy", 32'(tx_busy_o), 32'd0);
        chk("midrst_done", 32'(tx_done_o), 32'd0);
        reset = 1'b0;
        repeat (3 * CLK_DIV) begin
            @(negedge clk);
            chk("postrst_busy", 32'(tx_busy_o), 32'd0);
            chk("postrst_tx", 32'(tx_o), 32'd1);
        end
        start_tx_i = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_ctrl.md
UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 16: clock cycles per serial bit; legal range 2..65535.
REQ-002 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port start_tx_i, input, 1: level request from the control register; a rising edge launches one frame.
REQ-005 SHALL have port tx_data_i, input, 32: transmit data; only bits [7:0] are used.
REQ-006 SHALL have port data_bit_num_i, input, 2: data bits per frame; 00=5, 01=6, 10=7, 11=8.
REQ-007 SHALL have port stop_bit_num_i, input, 1: stop bits; 0=1, 1=2.
REQ-008 SHALL have port parity_en_i, input, 1: 1 inserts a parity bit.
REQ-009 SHALL have port parity_type_i, input, 1: 0=even, 1=odd.
REQ-010 SHALL have port tx_o, output, 1: serial line; idles at 1.
REQ-011 SHALL have port tx_busy_o, output, 1: frame in progress.
REQ-012 SHALL have port tx_done_o, output, 1: sticky frame-complete status.

Function
REQ-013 SHALL register start_tx_i into start_q each cycle; a launch occurs when start_tx_i=1, start_q=0 and state=IDLE.
REQ-014 SHALL latch tx_data_i[7:0] and all four config inputs at launch; later input changes SHALL NOT affect the current frame.
REQ-015 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-016 Transitions: IDLE->START on launch; START->DATA after CLK_DIV cycles; DATA->PARITY (parity enabled) or DATA->STOP after N data bits; PARITY->STOP after one bit; STOP->IDLE after 1 or 2 stop bits.
REQ-017 Each bit SHALL last exactly CLK_DIV cycles, timed by a 0..CLK_DIV-1 counter that clears on launch and wraps at each bit boundary.
REQ-018 tx_o SHALL be registered: 1 in IDLE and STOP, 0 in START, LSB-first data in DATA, and the parity bit in PARITY.
REQ-019 Parity bit SHALL be the XOR of the N transmitted data bits for even parity, and its inverse for odd parity.
REQ-020 tx_o SHALL go low on the clock edge of launch; the frame SHALL occupy CLK_DIV*(1+N+P+S) cycles, where P=parity_en and S=stop count.
REQ-021 tx_busy_o SHALL be 1 in every state except IDLE.
REQ-022 tx_done_o SHALL set on the edge that enters IDLE from STOP and SHALL clear on the next launch; it SHALL hold in all other cycles.
REQ-023 A rising edge of start_tx_i while busy SHALL be ignored and not queued; start_tx_i held high across frame completion SHALL NOT relaunch.
REQ-024 Because IDLE is entered only after the last stop bit, back-to-back frames SHALL have at least one idle cycle.

Reset
REQ-025 On reset SHALL give: state=IDLE, tx_o=1, tx_busy_o=0, tx_done_o=0, bit counter=0, latched data/config=0.
REQ-026 start_q SHALL reset to 1, so a start_tx_i already high at reset release does not launch.
REQ-027 Reset asserted mid-frame SHALL abort the frame; tx_o SHALL be 1 from the next edge.

Structure
REQ-028 Package uart_pkg SHALL hold the tx state enum and the data_bit_num, stop_bit_num and parity_type encodings.
REQ-029 The bit-period counter SHALL be sub-module uart_baud_gen (inputs clk, reset, clr; output tick on count CLK_DIV-1).

Verification (CLK_DIV=4)
REQ-030 8N1, data 0x55, start 0->1: tx_o = 0 for 4 cycles, then 1,0,1,0,1,0,1,0 (4 cycles each), then 1 for 4 cycles; tx_done_o=1 exactly 40 cycles after launch.
REQ-031 5 data bits, even parity, 2 stop, data 0x1F: tx_o = 0,1,1,1,1,1,1(parity),1,1; frame 36 cycles.
REQ-032 7 data bits, odd parity, data 0x00: seven 0 bits, then parity bit 1; frame 40 cycles.
REQ-033 start_tx_i held 1 through completion -> exactly one frame; drop to 0 then raise to 1 -> second frame; tx_done_o clears on that launch edge.
REQ-034 reset pulsed in DATA bit 3 -> next cycle tx_o=1, tx_busy_o=0, tx_done_o=0; start_tx_i held 1 after reset -> no frame.
REQ-035 data_bit_num_i changed 11->00 and tx_data_i changed mid-frame -> frame finishes with 8 bits of the original data.
